// File: rtl/return_stack_ctrl.sv
// return_stack_ctrl: on-chip circular return-address stack with spill/fill to data memory.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module return_stack_ctrl #(
  parameter int                    PC_WIDTH    = 12,
  parameter int                    DEPTH       = 16,
  parameter int                    SPILL_DEPTH = 64,
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] SPILL_BASE  = 8'hC0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  call,
  input  logic                  ret,
  input  logic [PC_WIDTH-1:0]   called_from,
  input  logic                  clear_faults,
  output logic [PC_WIDTH-1:0]   return_to,
  output logic                  stall,
  output logic [7:0]            depth,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [PC_WIDTH-1:0]   mem_wdata,
  input  logic [PC_WIDTH-1:0]   mem_rdata,
  input  logic                  mem_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OC_W  = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(SPILL_DEPTH + 1);

  localparam logic [OC_W-1:0] c_oc_full = OC_W'(DEPTH);
  localparam logic [SC_W-1:0] c_sc_full = SC_W'(SPILL_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [PC_WIDTH-1:0]   r_stack [DEPTH];
  logic [PTR_W-1:0]      r_tail;
  logic [OC_W-1:0]       r_oc;
  logic [SC_W-1:0]       r_sc;
  logic [PC_WIDTH-1:0]   r_push_val;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [PC_WIDTH-1:0]   r_mem_wdata;

  logic [PTR_W-1:0]      w_head_idx;
  logic [PTR_W-1:0]      w_top_idx;
  logic [PC_WIDTH-1:0]   w_push_val;
  logic                  w_oc_empty;
  logic                  w_empty;
  logic                  w_oc_full;
  logic                  w_sc_full;

  logic                  w_do_push;
  logic                  w_do_replace;
  logic                  w_do_pop;
  logic                  w_start_spill;
  logic                  w_start_fill;
  logic                  w_spill_done;
  logic                  w_fill_done;
  logic                  w_set_ovf;
  logic                  w_set_unf;

  logic                  w_wr_en;
  logic [PTR_W-1:0]      w_wr_idx;
  logic [PC_WIDTH-1:0]   w_wr_data;

  // Top sits at tail+oc-1; when oc==DEPTH the truncated sum wraps onto tail-1.
  assign w_head_idx = r_tail + r_oc[PTR_W-1:0];
  assign w_top_idx  = w_head_idx - PTR_W'(1);
  assign w_push_val = called_from + PC_WIDTH'(1);
  assign w_oc_empty = (r_oc == '0);
  assign w_empty    = w_oc_empty && (r_sc == '0);
  assign w_oc_full  = (r_oc == c_oc_full);
  assign w_sc_full  = (r_sc == c_sc_full);

  always_comb begin
    w_state_nxt   = r_state;
    w_do_push     = 1'b0;
    w_do_replace  = 1'b0;
    w_do_pop      = 1'b0;
    w_start_spill = 1'b0;
    w_start_fill  = 1'b0;
    w_spill_done  = 1'b0;
    w_fill_done   = 1'b0;
    w_set_ovf     = 1'b0;
    w_set_unf     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (call && ret && !w_empty) begin
          w_do_replace = 1'b1;
        end else if (call) begin
          if (!w_oc_full) begin
            w_do_push = 1'b1;
          end else if (!w_sc_full) begin
            w_start_spill = 1'b1;
            w_state_nxt   = ST_SPILL;
          end else begin
            w_set_ovf = 1'b1;
          end
        end else if (ret) begin
          if (w_empty) begin
            w_set_unf = 1'b1;
          end else begin
            w_do_pop = 1'b1;
            if ((r_oc == OC_W'(1)) && (r_sc != '0)) begin
              w_start_fill = 1'b1;
              w_state_nxt  = ST_FILL;
            end
          end
        end
      end
      ST_SPILL: begin
        if (r_mem_req && mem_ack) begin
          w_spill_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (r_mem_req && mem_ack) begin
          w_fill_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // After a spill the vacated tail slot becomes the new top, so both
  // spill and fill completion write at the pre-update tail index.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = w_head_idx;
    w_wr_data = w_push_val;
    if (w_do_push) begin
      w_wr_en = 1'b1;
    end else if (w_do_replace) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (w_spill_done) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_tail;
      w_wr_data = r_push_val;
    end else if (w_fill_done) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_tail;
      w_wr_data = mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_stack[w_wr_idx] <= w_wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tail      <= '0;
      r_oc        <= '0;
      r_sc        <= '0;
      r_push_val  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= SPILL_BASE;
      r_mem_wdata <= '0;
    end else begin
      r_overflow  <= w_set_ovf | (r_overflow & ~clear_faults);
      r_underflow <= w_set_unf | (r_underflow & ~clear_faults);
      if (w_do_push) begin
        r_oc <= r_oc + OC_W'(1);
      end
      if (w_do_pop) begin
        r_oc <= r_oc - OC_W'(1);
      end
      if (w_start_spill) begin
        r_push_val  <= w_push_val;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= SPILL_BASE + ADDR_WIDTH'(r_sc);
        r_mem_wdata <= r_stack[r_tail];
      end
      if (w_start_fill) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= SPILL_BASE + ADDR_WIDTH'(r_sc - SC_W'(1));
      end
      if (w_spill_done) begin
        r_mem_req <= 1'b0;
        r_sc      <= r_sc + SC_W'(1);
        r_tail    <= r_tail + PTR_W'(1);
      end
      if (w_fill_done) begin
        r_mem_req <= 1'b0;
        r_sc      <= r_sc - SC_W'(1);
        r_oc      <= OC_W'(1);
      end
    end
  end

  // During a fill no entry is on-chip yet, so the top reads as 0 until the refill lands.
  assign return_to = w_oc_empty ? '0 : r_stack[w_top_idx];
  assign stall     = (r_state != ST_IDLE);
  assign depth     = 8'(r_oc) + 8'(r_sc);
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_return_stack_ctrl.sv
// tb_return_stack_ctrl: directed checks of push/pop, spill/fill, faults and async reset.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_return_stack_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        call;
  logic        ret;
  logic [11:0] called_from;
  logic        clear_faults;
  logic [11:0] return_to;
  logic        stall;
  logic [7:0]  depth;
  logic        overflow;
  logic        underflow;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        mem_ack;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_delay = 1;
  int          stall_cycles;
  logic        cap_req;
  logic        cap_we;
  logic [7:0]  cap_addr;
  logic [11:0] cap_wdata;
  logic [11:0] spill_mem [256];

  return_stack_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .call         (call),
    .ret          (ret),
    .called_from  (called_from),
    .clear_faults (clear_faults),
    .return_to    (return_to),
    .stall        (stall),
    .depth        (depth),
    .overflow     (overflow),
    .underflow    (underflow),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: ack on the ack_delay-th cycle that mem_req is seen high.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      mem_ack = 1'b0;
      if (mem_req && reset_n) begin
        cnt++;
        if (cnt >= ack_delay) begin
          cnt     = 0;
          mem_ack = 1'b1;
          if (mem_we) spill_mem[mem_addr] = mem_wdata;
          else        mem_rdata = spill_mem[mem_addr];
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic capture();
    if (mem_req && !cap_req) begin
      cap_req   = 1'b1;
      cap_we    = mem_we;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
    end
  endtask

  task automatic op(input logic c, input logic r, input logic cf, input logic [11:0] pc);
    @(posedge clock); #1;
    call = c; ret = r; clear_faults = cf; called_from = pc;
    @(posedge clock); #1;
    call = 1'b0; ret = 1'b0; clear_faults = 1'b0;
    cap_req      = 1'b0;
    stall_cycles = 0;
    capture();
    while (stall && stall_cycles < 300) begin
      @(posedge clock); #1;
      stall_cycles++;
      capture();
    end
    if (stall) chk("stall_timeout", 32'(stall), 32'h0);
  endtask

  initial begin
    reset_n      = 1'b0;
    call         = 1'b0;
    ret          = 1'b0;
    called_from  = '0;
    clear_faults = 1'b0;
    #12;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'hC0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_return_to", 32'(return_to), 32'h0);
    chk("rst_depth", 32'(depth), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_unf", 32'(underflow), 32'h0);
    #10 reset_n = 1'b1;

    // Plain push/pop
    op(1, 0, 0, 12'h010); chk("p1_rt", 32'(return_to), 32'h011); chk("p1_d", 32'(depth), 32'd1);
    chk("p1_stall", 32'(stall_cycles), 32'd0);
    op(1, 0, 0, 12'h020); chk("p2_rt", 32'(return_to), 32'h021); chk("p2_d", 32'(depth), 32'd2);
    op(1, 0, 0, 12'h030); chk("p3_rt", 32'(return_to), 32'h031); chk("p3_d", 32'(depth), 32'd3);
    op(0, 1, 0, 12'h0);   chk("r1_rt", 32'(return_to), 32'h021); chk("r1_d", 32'(depth), 32'd2);
    op(0, 1, 0, 12'h0);   chk("r2_rt", 32'(return_to), 32'h011); chk("r2_d", 32'(depth), 32'd1);
    op(0, 1, 0, 12'h0);   chk("r3_rt", 32'(return_to), 32'h000); chk("r3_d", 32'(depth), 32'd0);
    chk("r3_stall", 32'(stall_cycles), 32'd0);

    // Spill with 3-cycle ack
    ack_delay = 3;
    for (int i = 0; i < 16; i++) op(1, 0, 0, 12'(i));
    chk("s16_d", 32'(depth), 32'd16);
    chk("s16_rt", 32'(return_to), 32'h010);
    op(1, 0, 0, 12'd16);
    chk("s17_req", 32'(cap_req), 32'h1);
    chk("s17_we", 32'(cap_we), 32'h1);
    chk("s17_addr", 32'(cap_addr), 32'hC0);
    chk("s17_wdata", 32'(cap_wdata), 32'h001);
    chk("s17_stall", 32'(stall_cycles), 32'd3);
    chk("s17_rt", 32'(return_to), 32'h011);
    chk("s17_d", 32'(depth), 32'd17);

    // Unwind through a fill
    for (int k = 1; k <= 15; k++) op(0, 1, 0, 12'h0);
    chk("u15_rt", 32'(return_to), 32'h002);
    chk("u15_d", 32'(depth), 32'd2);
    op(0, 1, 0, 12'h0);
    chk("u16_req", 32'(cap_req), 32'h1);
    chk("u16_we", 32'(cap_we), 32'h0);
    chk("u16_addr", 32'(cap_addr), 32'hC0);
    chk("u16_stall", 32'(stall_cycles), 32'd3);
    chk("u16_rt", 32'(return_to), 32'h001);
    chk("u16_d", 32'(depth), 32'd1);
    op(0, 1, 0, 12'h0);
    chk("u17_rt", 32'(return_to), 32'h000);
    chk("u17_d", 32'(depth), 32'd0);
    chk("u17_unf", 32'(underflow), 32'h0);

    // Fill to capacity, overflow, then unwind all 80
    ack_delay = 1;
    for (int i = 0; i < 80; i++) op(1, 0, 0, 12'(i));
    chk("f80_d", 32'(depth), 32'd80);
    chk("f80_rt", 32'(return_to), 32'h050);
    op(1, 0, 0, 12'h123);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_d", 32'(depth), 32'd80);
    chk("ovf_noreq", 32'(cap_req), 32'h0);
    chk("ovf_rt", 32'(return_to), 32'h050);
    for (int k = 1; k <= 80; k++) begin
      op(0, 1, 0, 12'h0);
      chk($sformatf("unw%0d_rt", k), 32'(return_to), 32'(80 - k));
    end
    chk("unw_d", 32'(depth), 32'd0);
    chk("unw_ovf_sticky", 32'(overflow), 32'h1);
    op(0, 1, 0, 12'h0);
    chk("unf_flag", 32'(underflow), 32'h1);
    chk("unf_rt", 32'(return_to), 32'h0);
    op(0, 0, 1, 12'h0);
    chk("clr_ovf", 32'(overflow), 32'h0);
    chk("clr_unf", 32'(underflow), 32'h0);
    op(0, 1, 1, 12'h0);
    chk("clr_set_wins", 32'(underflow), 32'h1);
    op(0, 0, 1, 12'h0);
    chk("clr_again", 32'(underflow), 32'h0);

    // Simultaneous call+ret
    op(1, 1, 0, 12'h300);
    chk("cr0_rt", 32'(return_to), 32'h301);
    chk("cr0_d", 32'(depth), 32'd1);
    chk("cr0_unf", 32'(underflow), 32'h0);
    op(0, 1, 0, 12'h0);
    op(1, 0, 0, 12'h050);
    op(1, 0, 0, 12'h100);
    chk("cr_pre_rt", 32'(return_to), 32'h101);
    op(1, 1, 0, 12'h200);
    chk("cr_rt", 32'(return_to), 32'h201);
    chk("cr_d", 32'(depth), 32'd2);
    chk("cr_noreq", 32'(cap_req), 32'h0);
    op(0, 1, 0, 12'h0);
    chk("cr_pop_rt", 32'(return_to), 32'h051);
    chk("cr_pop_d", 32'(depth), 32'd1);

    // Async reset during a spill
    @(posedge clock); #2 reset_n = 1'b0;
    #4 reset_n = 1'b1;
    for (int i = 0; i < 16; i++) op(1, 0, 0, 12'(i));
    ack_delay = 1000;
    @(posedge clock); #1;
    call = 1'b1; called_from = 12'h0AA;
    @(posedge clock); #1;
    call = 1'b0;
    @(posedge clock); #1;
    chk("mid_req", 32'(mem_req), 32'h1);
    chk("mid_stall", 32'(stall), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_d", 32'(depth), 32'd0);
    chk("arst_rt", 32'(return_to), 32'h0);
    @(posedge clock); #1 reset_n = 1'b1;
    ack_delay = 1;
    op(1, 0, 0, 12'h040);
    chk("post_rt", 32'(return_to), 32'h041);
    chk("post_d", 32'(depth), 32'd1);
    chk("post_stall", 32'(stall_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
